// File: rtl/master_fsm_multi_if.sv
// master_fsm_multi_if: bundles the button pulses going into the sequencing
// FSM and the state/shift/level signals coming out of it.
//   master modport: the pulse source (debounced buttons, or a bench)
//   slave modport : the sequencing FSM itself
//
// Handshake semantics: next/prev/faster/slower are single-cycle pulses
// sampled at the rising clock edge. There is no ready/backpressure path;
// every pulse is consumed in the cycle it is present. shift_left and
// shift_right are single-cycle registered pulses with the same meaning
// toward the tempo shifters.
interface master_fsm_multi_if #(
  parameter int NUM_CH  = 2,
  parameter int STATE_W = 3,
  parameter int SPEED_W = 3
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                      next;
  logic                      prev;
  logic                      faster;
  logic                      slower;
  logic [STATE_W-1:0]        state;
  logic                      edit_active;
  logic [CH_W-1:0]           edit_ch;
  logic [NUM_CH-1:0]         shift_left;
  logic [NUM_CH-1:0]         shift_right;
  logic [NUM_CH*SPEED_W-1:0] speed_level;
  logic [NUM_CH-1:0]         at_limit;

  modport master (
    output next, prev, faster, slower,
    input  state, edit_active, edit_ch, shift_left, shift_right,
           speed_level, at_limit
  );

  modport slave (
    input  next, prev, faster, slower,
    output state, edit_active, edit_ch, shift_left, shift_right,
           speed_level, at_limit
  );
endinterface

// File: rtl/master_fsm_multi.sv
// master_fsm_multi: ring of idle/play/view/edit states for NUM_CH channels.
// State ring: 0 = idle, 1 = play, channel i view = 2i+2, edit = 2i+3.
// In a channel's edit state, faster/slower pulses become one-cycle
// registered shift pulses and move a saturating per-channel speed level.
//
// Optional feature (macro MASTER_FSM_EDIT_TIMEOUT_EN): an idle counter that
// drops an edit state back to its view state after TIMEOUT_CYCLES cycles
// without any input pulse. With the macro undefined no counter exists and
// edit states persist until next/prev.
//
// The registered state is visible on bus.state for checkers.
module master_fsm_multi #(
  parameter int NUM_CH         = 2,
  parameter int STATE_W        = 3,
  parameter int SPEED_W        = 3,
  parameter int SPEED_INIT     = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input logic               clock,
  input logic               reset,
  master_fsm_multi_if.slave bus
);

  localparam int NUM_STATES = 2 * NUM_CH + 2;
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [SPEED_W-1:0] LEVEL_MAX  = '1;
  localparam logic [SPEED_W-1:0] LEVEL_INIT = SPEED_W'(SPEED_INIT);
  localparam logic               INIT_AT_LIMIT =
    (LEVEL_INIT == '0) || (LEVEL_INIT == LEVEL_MAX);

  // Refuse to elaborate a ring that does not fit in the state register or
  // a timeout that could never count.
  if (((2 ** STATE_W) < NUM_STATES) || (TIMEOUT_CYCLES < 1)) begin : g_bad_config
    $error("master_fsm_multi: STATE_W too small for ring, or TIMEOUT_CYCLES < 1");
  end

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [NUM_CH-1:0]  edit_sel;     // one-hot: which channel's edit state we are in
  logic               is_edit;
  logic [CH_W-1:0]    edit_ch_c;
  logic               timeout_fire;

  // ---------------------------------------------------------------------
  // Per-channel speed levels and shift pulses
  // ---------------------------------------------------------------------
  logic [SPEED_W-1:0]        level_q [NUM_CH];
  logic [SPEED_W-1:0]        level_d [NUM_CH];
  logic [NUM_CH-1:0]         shift_left_q;
  logic [NUM_CH-1:0]         shift_left_d;
  logic [NUM_CH-1:0]         shift_right_q;
  logic [NUM_CH-1:0]         shift_right_d;
  logic [NUM_CH-1:0]         at_limit_q;
  logic [NUM_CH-1:0]         at_limit_d;
  logic [NUM_CH*SPEED_W-1:0] speed_flat;

  // State register: the ring position, cleared to idle by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: next/prev step the ring with wrap, both together
  // cancel, illegal encodings recover to idle, and an expired edit timeout
  // steps back to the channel's view state only when no pulse is present.
  always_comb begin
    state_d = state_q;
    if (state_q > LAST_STATE) begin
      state_d = '0;
    end else if (bus.next && !bus.prev) begin
      state_d = (state_q == LAST_STATE) ? '0 : state_q + STATE_W'(1);
    end else if (bus.prev && !bus.next) begin
      state_d = (state_q == '0) ? LAST_STATE : state_q - STATE_W'(1);
    end else if (timeout_fire) begin
      state_d = state_q - STATE_W'(1);
    end
  end

  // Output decode: which edit state (if any) the registered state is in.
  always_comb begin
    edit_sel  = '0;
    is_edit   = 1'b0;
    edit_ch_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == STATE_W'(2 * i + 3)) begin
        edit_sel[i] = 1'b1;
        is_edit     = 1'b1;
        edit_ch_c   = CH_W'(i);
      end
    end
  end

  // Shift decision: uses the pre-transition state, so a shift and a
  // next/prev in the same cycle both take effect. A level at its end stop
  // swallows the request entirely (no pulse, no wrap).
  always_comb begin
    shift_left_d  = '0;
    shift_right_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      level_d[i] = level_q[i];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (edit_sel[i]) begin
        if (bus.faster && !bus.slower && (level_q[i] != LEVEL_MAX)) begin
          shift_left_d[i] = 1'b1;
          level_d[i]      = level_q[i] + SPEED_W'(1);
        end else if (bus.slower && !bus.faster && (level_q[i] != '0)) begin
          shift_right_d[i] = 1'b1;
          level_d[i]       = level_q[i] - SPEED_W'(1);
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      at_limit_d[i] = (level_d[i] == '0) || (level_d[i] == LEVEL_MAX);
    end
  end

  // Level, shift-pulse and limit-flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_left_q  <= '0;
      shift_right_q <= '0;
      at_limit_q    <= {NUM_CH{INIT_AT_LIMIT}};
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= LEVEL_INIT;
      end
    end else begin
      shift_left_q  <= shift_left_d;
      shift_right_q <= shift_right_d;
      at_limit_q    <= at_limit_d;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  // Pack the per-channel levels, channel i at [i*SPEED_W +: SPEED_W].
  always_comb begin
    speed_flat = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      speed_flat[i*SPEED_W +: SPEED_W] = level_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // Optional edit-state idle timeout
  // ---------------------------------------------------------------------
`ifdef MASTER_FSM_EDIT_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            any_pulse;

  // Idle counting: runs only in an edit state with no pulse. Any pulse,
  // any state change, and being outside an edit state all hold it at zero,
  // so entering an edit state always starts from zero.
  always_comb begin
    any_pulse    = bus.next | bus.prev | bus.faster | bus.slower;
    timeout_fire = is_edit && !any_pulse && (to_cnt_q == TO_LAST);
    if (is_edit && !any_pulse && !timeout_fire) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = '0;
    end
  end

  // Idle counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.state       = state_q;
  assign bus.edit_active = is_edit;
  assign bus.edit_ch     = edit_ch_c;
  assign bus.shift_left  = shift_left_q;
  assign bus.shift_right = shift_right_q;
  assign bus.speed_level = speed_flat;
  assign bus.at_limit    = at_limit_q;

endmodule

// File: tb/tb_master_fsm_multi.sv
// tb_master_fsm_multi: directed vector table, hand sequences for reset and
// timeout corners, and a randomized run against a behavioural model.
module tb_master_fsm_multi;

  localparam int NUM_CH         = 2;
  localparam int STATE_W        = 3;
  localparam int SPEED_W        = 3;
  localparam int SPEED_INIT     = 4;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int NS             = 2 * NUM_CH + 2;
  localparam int LMAX           = (1 << SPEED_W) - 1;
  localparam int VW             = 17;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  master_fsm_multi_if #(.NUM_CH(NUM_CH), .STATE_W(STATE_W), .SPEED_W(SPEED_W)) bus ();

  master_fsm_multi #(
    .NUM_CH(NUM_CH), .STATE_W(STATE_W), .SPEED_W(SPEED_W),
    .SPEED_INIT(SPEED_INIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [VW-1:0] exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // ---------------- behavioural model ----------------
  int m_state;
  int m_lvl[NUM_CH];
  int m_shl;
  int m_shr;
  int m_idle;

  function automatic bit m_is_edit(input int s);
    return (s >= 3) && (s < NS) && (s % 2 == 1);
  endfunction

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < NUM_CH; i++) m_lvl[i] = SPEED_INIT;
    m_shl  = 0;
    m_shr  = 0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit n, input bit p, input bit f, input bit s);
    bit ed;
    int ch;
    bit fire;
    ed   = m_is_edit(m_state);
    ch   = ed ? (m_state - 3) / 2 : 0;
    m_shl = 0;
    m_shr = 0;
    if (ed && f && !s && m_lvl[ch] < LMAX) begin
      m_lvl[ch] = m_lvl[ch] + 1;
      m_shl     = 1 << ch;
    end else if (ed && s && !f && m_lvl[ch] > 0) begin
      m_lvl[ch] = m_lvl[ch] - 1;
      m_shr     = 1 << ch;
    end
    fire = 1'b0;
`ifdef MASTER_FSM_EDIT_TIMEOUT_EN
    begin
      bit any_in;
      any_in = n | p | f | s;
      fire   = ed && !any_in && (m_idle == TIMEOUT_CYCLES - 1);
      m_idle = (ed && !any_in && !fire) ? m_idle + 1 : 0;
    end
`endif
    if (fire) m_state = m_state - 1;
    else if (n && !p) m_state = (m_state + 1) % NS;
    else if (p && !n) m_state = (m_state + NS - 1) % NS;
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [VW-1:0] v;
    int lim;
    lim = 0;
    for (int i = 0; i < NUM_CH; i++)
      if (m_lvl[i] == 0 || m_lvl[i] == LMAX) lim = lim | (1 << i);
    v[16:14] = 3'(m_state);
    v[13:12] = 2'(m_shl);
    v[11:10] = 2'(m_shr);
    v[9:4]   = 6'(m_lvl[1] * 8 + m_lvl[0]);
    v[3:2]   = 2'(lim);
    v[1]     = m_is_edit(m_state);
    v[0]     = m_is_edit(m_state) ? 1'((m_state - 3) / 2) : 1'b0;
    return v;
  endfunction

  task automatic compare_vec(input string tag, input logic [VW-1:0] e);
    check({tag, ".state"},       int'(bus.state),       int'(e[16:14]));
    check({tag, ".shift_left"},  int'(bus.shift_left),  int'(e[13:12]));
    check({tag, ".shift_right"}, int'(bus.shift_right), int'(e[11:10]));
    check({tag, ".speed_level"}, int'(bus.speed_level), int'(e[9:4]));
    check({tag, ".at_limit"},    int'(bus.at_limit),    int'(e[3:2]));
    check({tag, ".edit_active"}, int'(bus.edit_active), int'(e[1]));
    check({tag, ".edit_ch"},     int'(bus.edit_ch),     int'(e[0]));
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: present the pulses for one rising edge,
  // return at the next falling edge with the pulses removed.
  task automatic cycle(input bit n, input bit p, input bit f, input bit s);
    bus.next   = n;
    bus.prev   = p;
    bus.faster = f;
    bus.slower = s;
    @(negedge clock);
    bus.next   = 1'b0;
    bus.prev   = 1'b0;
    bus.faster = 1'b0;
    bus.slower = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    bus.next   = 1'b0;
    bus.prev   = 1'b0;
    bus.faster = 1'b0;
    bus.slower = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit n;
    bit p;
    bit f;
    bit s;
    int st;
    int shl;
    int shr;
    int l0;
    int l1;
  } vec_t;

  vec_t tbl[$];

  task automatic fill_table();
    tbl.push_back('{1,0,0,0, 1,0,0,4,4});
    tbl.push_back('{1,0,0,0, 2,0,0,4,4});
    tbl.push_back('{1,0,0,0, 3,0,0,4,4});
    tbl.push_back('{1,0,0,0, 4,0,0,4,4});
    tbl.push_back('{1,0,0,0, 5,0,0,4,4});
    tbl.push_back('{1,0,0,0, 0,0,0,4,4});
    tbl.push_back('{0,1,0,0, 5,0,0,4,4});
    tbl.push_back('{1,1,0,0, 5,0,0,4,4});
    tbl.push_back('{0,0,0,1, 5,0,2,4,3});
    tbl.push_back('{0,0,0,1, 5,0,2,4,2});
    tbl.push_back('{0,0,0,1, 5,0,2,4,1});
    tbl.push_back('{0,0,0,1, 5,0,2,4,0});
    tbl.push_back('{0,0,0,1, 5,0,0,4,0});
    tbl.push_back('{0,0,1,1, 5,0,0,4,0});
    tbl.push_back('{0,0,0,0, 5,0,0,4,0});
    tbl.push_back('{0,0,1,0, 5,2,0,4,1});
    tbl.push_back('{1,0,0,0, 0,0,0,4,1});
    tbl.push_back('{0,0,1,0, 0,0,0,4,1});
    tbl.push_back('{1,0,0,0, 1,0,0,4,1});
    tbl.push_back('{1,0,0,0, 2,0,0,4,1});
    tbl.push_back('{0,0,1,0, 2,0,0,4,1});
    tbl.push_back('{1,0,0,0, 3,0,0,4,1});
    tbl.push_back('{0,0,1,0, 3,1,0,5,1});
    tbl.push_back('{0,0,1,0, 3,1,0,6,1});
    tbl.push_back('{0,0,1,0, 3,1,0,7,1});
    tbl.push_back('{0,0,1,0, 3,0,0,7,1});
    tbl.push_back('{1,0,0,1, 4,0,1,6,1});
    tbl.push_back('{0,1,0,0, 3,0,0,6,1});
    tbl.push_back('{1,0,1,0, 4,1,0,7,1});
    tbl.push_back('{0,0,0,0, 4,0,0,7,1});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.next   = 1'b0;
    bus.prev   = 1'b0;
    bus.faster = 1'b0;
    bus.slower = 1'b0;

    // Reset values
    do_reset();
    check("reset.state",       int'(bus.state),       0);
    check("reset.shift_left",  int'(bus.shift_left),  0);
    check("reset.shift_right", int'(bus.shift_right), 0);
    check("reset.speed_level", int'(bus.speed_level), SPEED_INIT * 8 + SPEED_INIT);
    check("reset.at_limit",    int'(bus.at_limit),    0);
    check("reset.edit_active", int'(bus.edit_active), 0);
    check("reset.edit_ch",     int'(bus.edit_ch),     0);

    // Directed table
    fill_table();
    for (int k = 0; k < tbl.size(); k++) begin
      int lim;
      int ed;
      string tag;
      tag = $sformatf("tbl%0d", k);
      cycle(tbl[k].n, tbl[k].p, tbl[k].f, tbl[k].s);
      lim = ((tbl[k].l0 == 0 || tbl[k].l0 == LMAX) ? 1 : 0) |
            ((tbl[k].l1 == 0 || tbl[k].l1 == LMAX) ? 2 : 0);
      ed  = (tbl[k].st == 3 || tbl[k].st == 5) ? 1 : 0;
      check({tag, ".state"},       int'(bus.state),       tbl[k].st);
      check({tag, ".shift_left"},  int'(bus.shift_left),  tbl[k].shl);
      check({tag, ".shift_right"}, int'(bus.shift_right), tbl[k].shr);
      check({tag, ".level0"},      int'(bus.speed_level[2:0]), tbl[k].l0);
      check({tag, ".level1"},      int'(bus.speed_level[5:3]), tbl[k].l1);
      check({tag, ".at_limit"},    int'(bus.at_limit),    lim);
      check({tag, ".edit_active"}, int'(bus.edit_active), ed);
      check({tag, ".edit_ch"},     int'(bus.edit_ch),     (tbl[k].st == 5) ? 1 : 0);
    end

    // Reset asserted while a shift pulse is being presented
    cycle(0, 1, 0, 0);
    check("midrst.enter_state", int'(bus.state), 3);
    bus.slower = 1'b1;
    @(posedge clock);
    #1;
    bus.slower = 1'b0;
    check("midrst.pulse",  int'(bus.shift_right), 1);
    check("midrst.level0", int'(bus.speed_level[2:0]), 6);
    reset = 1'b0;
    #1;
    check("midrst.state",       int'(bus.state),       0);
    check("midrst.shift_right", int'(bus.shift_right), 0);
    check("midrst.speed_level", int'(bus.speed_level), SPEED_INIT * 8 + SPEED_INIT);
    check("midrst.at_limit",    int'(bus.at_limit),    0);
    check("midrst.edit_active", int'(bus.edit_active), 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    cycle(0, 0, 0, 0);
    check("postrst.shift_left",  int'(bus.shift_left),  0);
    check("postrst.shift_right", int'(bus.shift_right), 0);
    check("postrst.state",       int'(bus.state),       0);

`ifdef MASTER_FSM_EDIT_TIMEOUT_EN
    // Idle timeout: edit state 3 drops to view 2 exactly 8 cycles after entry
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    check("to.entry", int'(bus.state), 3);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("to.hold%0d", k), int'(bus.state), 3);
    end
    cycle(0, 0, 0, 0);
    check("to.expire", int'(bus.state), 2);
    // A faster pulse on cycle 7 restarts the count
    cycle(1, 0, 0, 0);
    check("to2.entry", int'(bus.state), 3);
    for (int k = 1; k < TIMEOUT_CYCLES - 1; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("to2.hold%0d", k), int'(bus.state), 3);
    end
    cycle(0, 0, 1, 0);
    check("to2.pulse_state", int'(bus.state), 3);
    check("to2.pulse_shl",   int'(bus.shift_left), 1);
    for (int k = 1; k < TIMEOUT_CYCLES; k++) begin
      cycle(0, 0, 0, 0);
      check($sformatf("to2.rehold%0d", k), int'(bus.state), 3);
    end
    cycle(0, 0, 0, 0);
    check("to2.expire", int'(bus.state), 2);
`endif

    // Randomized run against the behavioural model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      bit n, p, f, s;
      n = ($urandom_range(0, 6) == 0);
      p = ($urandom_range(0, 7) == 0);
      f = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 2) == 0);
      model_step(n, p, f, s);
      exp_q.push_back(model_vec());
      cycle(n, p, f, s);
      compare_vec($sformatf("rnd%0d", k), exp_q.pop_front());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
